// File: rtl/max_share_arbiter_pkg.sv
// rtl/max_share_arbiter_pkg.sv - shared widths, requester ids, port FSM states and tag type
package max_share_arbiter_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int ACTIONS       = 4;
    localparam int ACTIONS_WIDTH = 2;
    localparam int MAX_LATENCY   = ACTIONS_WIDTH + 1;

    localparam logic REQ_POL = 1'b0;
    localparam logic REQ_UPD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } port_state_t;

    // One slot of the in-flight tag pipeline.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/max_req_port.sv
// rtl/max_req_port.sv - per-requester FSM with result hold register and response handshake
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_req                    requester wants an issue slot
//   i_grant                  arbiter granted this port in the current cycle
//   i_ret_valid              tagged result for this port is present on i_ret_data/i_ret_idx
//   i_ret_abort              tagged slot for this port came back without a result
//   i_ret_data, i_ret_idx    max value and index from the max-finder
//   i_rsp_ready              requester consumes the held result
//   o_eligible               port is IDLE and requesting
//   o_ack                    one-cycle accept pulse, the cycle after the grant
//   o_rsp_valid              result is held
//   o_rsp_data, o_rsp_idx    held result
module max_req_port
    import max_share_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic                     i_grant,
    input  logic                     i_ret_valid,
    input  logic                     i_ret_abort,
    input  logic [DATA_WIDTH-1:0]    i_ret_data,
    input  logic [ACTIONS_WIDTH-1:0] i_ret_idx,
    input  logic                     i_rsp_ready,
    output logic                     o_eligible,
    output logic                     o_ack,
    output logic                     o_rsp_valid,
    output logic [DATA_WIDTH-1:0]    o_rsp_data,
    output logic [ACTIONS_WIDTH-1:0] o_rsp_idx
);

    port_state_t               r_state;
    port_state_t               w_state_next;
    logic                      r_ack;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic [ACTIONS_WIDTH-1:0]  r_rsp_idx;
    logic                      w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_grant) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_ret_valid) begin
                    w_state_next = HOLD;
                    w_capture    = 1'b1;
                end else if (i_ret_abort) begin
                    // Slot came back empty: give up on it so the port can re-request.
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (i_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_idx  <= '0;
        end else begin
            r_ack <= i_grant;
            if (w_capture) begin
                r_rsp_data <= i_ret_data;
                r_rsp_idx  <= i_ret_idx;
            end
        end
    end

    assign o_eligible  = (r_state == IDLE) && i_req;
    assign o_ack       = r_ack;
    assign o_rsp_valid = (r_state == HOLD);
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_idx   = r_rsp_idx;

endmodule

// File: rtl/max_share_arbiter.sv
// rtl/max_share_arbiter.sv - round-robin sharing of one pipelined argmax unit between policy and update paths
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pol_req/pol_data/pol_ack           policy request, Q-vector (channel 0 in LSBs), accept pulse
//   pol_rsp_valid/ready/data/idx       policy result handshake, max value and its index
//   upd_*                              same set for the update (Bellman target) path
//   mx_valid/mx_data                   issue to the max-finder
//   mx_o_valid/mx_o_data/mx_o_at_max   max-finder result
//   err_sync                           sticky result/tag mismatch flag
module max_share_arbiter
    import max_share_arbiter_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pol_req,
    input  logic [DATA_WIDTH*ACTIONS-1:0]    pol_data,
    output logic                             pol_ack,
    output logic                             pol_rsp_valid,
    input  logic                             pol_rsp_ready,
    output logic [DATA_WIDTH-1:0]            pol_rsp_data,
    output logic [ACTIONS_WIDTH-1:0]         pol_rsp_idx,
    input  logic                             upd_req,
    input  logic [DATA_WIDTH*ACTIONS-1:0]    upd_data,
    output logic                             upd_ack,
    output logic                             upd_rsp_valid,
    input  logic                             upd_rsp_ready,
    output logic [DATA_WIDTH-1:0]            upd_rsp_data,
    output logic [ACTIONS_WIDTH-1:0]         upd_rsp_idx,
    output logic                             mx_valid,
    output logic [DATA_WIDTH*ACTIONS-1:0]    mx_data,
    input  logic                             mx_o_valid,
    input  logic [DATA_WIDTH-1:0]            mx_o_data,
    input  logic [ACTIONS_WIDTH-1:0]         mx_o_at_max,
    output logic                             err_sync
);

    logic                           w_pol_elig;
    logic                           w_upd_elig;
    logic                           w_grant_pol;
    logic                           w_grant_upd;
    logic                           w_any_grant;
    logic                           r_rr_ptr;

    logic                           r_mx_valid;
    logic                           r_mx_id;
    logic [DATA_WIDTH*ACTIONS-1:0]  r_mx_data;

    tag_t                           r_tag [MAX_LATENCY];
    tag_t                           w_head;
    logic                           w_ret_ok;
    logic                           w_ret_miss;
    logic                           w_orphan;
    logic                           r_err_sync;

    // Arbitration: the pointer only matters when both ports are eligible.
    always_comb begin
        w_grant_pol = w_pol_elig && (!w_upd_elig || (r_rr_ptr == REQ_POL));
        w_grant_upd = w_upd_elig && !w_grant_pol;
        w_any_grant = w_grant_pol || w_grant_upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= REQ_POL;
        end else if (w_grant_pol) begin
            r_rr_ptr <= REQ_UPD;
        end else if (w_grant_upd) begin
            r_rr_ptr <= REQ_POL;
        end
    end

    // Issue registers: the winner's vector is captured at the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mx_valid <= 1'b0;
            r_mx_id    <= REQ_POL;
            r_mx_data  <= '0;
        end else begin
            r_mx_valid <= w_any_grant;
            if (w_any_grant) begin
                r_mx_id   <= w_grant_upd ? REQ_UPD : REQ_POL;
                r_mx_data <= w_grant_upd ? upd_data : pol_data;
            end
        end
    end

    // Tag pipeline runs in lockstep with the max-finder: the tag enters
    // stage 0 on the same edge the max-finder accepts mx_valid, so the head
    // lines up with mx_o_valid MAX_LATENCY cycles after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0].valid <= r_mx_valid;
            r_tag[0].id    <= r_mx_id;
            for (int i = 1; i < MAX_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_head     = r_tag[MAX_LATENCY-1];
    assign w_ret_ok   = w_head.valid && mx_o_valid;
    assign w_ret_miss = w_head.valid && !mx_o_valid;
    assign w_orphan   = !w_head.valid && mx_o_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sync <= 1'b0;
        end else if (w_ret_miss || w_orphan) begin
            r_err_sync <= 1'b1;
        end
    end

    max_req_port u_pol_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (pol_req),
        .i_grant     (w_grant_pol),
        .i_ret_valid (w_ret_ok && (w_head.id == REQ_POL)),
        .i_ret_abort (w_ret_miss && (w_head.id == REQ_POL)),
        .i_ret_data  (mx_o_data),
        .i_ret_idx   (mx_o_at_max),
        .i_rsp_ready (pol_rsp_ready),
        .o_eligible  (w_pol_elig),
        .o_ack       (pol_ack),
        .o_rsp_valid (pol_rsp_valid),
        .o_rsp_data  (pol_rsp_data),
        .o_rsp_idx   (pol_rsp_idx)
    );

    max_req_port u_upd_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (upd_req),
        .i_grant     (w_grant_upd),
        .i_ret_valid (w_ret_ok && (w_head.id == REQ_UPD)),
        .i_ret_abort (w_ret_miss && (w_head.id == REQ_UPD)),
        .i_ret_data  (mx_o_data),
        .i_ret_idx   (mx_o_at_max),
        .i_rsp_ready (upd_rsp_ready),
        .o_eligible  (w_upd_elig),
        .o_ack       (upd_ack),
        .o_rsp_valid (upd_rsp_valid),
        .o_rsp_data  (upd_rsp_data),
        .o_rsp_idx   (upd_rsp_idx)
    );

    assign mx_valid = r_mx_valid;
    assign mx_data  = r_mx_data;
    assign err_sync = r_err_sync;

endmodule

// File: tb/tb_max_share_arbiter.sv
// tb/tb_max_share_arbiter.sv - directed self-checking bench for max_share_arbiter with a 3-stage argmax model
module tb_max_share_arbiter;
    import max_share_arbiter_pkg::*;

    localparam int VW = DATA_WIDTH * ACTIONS;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     pol_req, upd_req;
    logic [VW-1:0]            pol_data, upd_data;
    logic                     pol_ack, upd_ack;
    logic                     pol_rsp_valid, upd_rsp_valid;
    logic                     pol_rsp_ready, upd_rsp_ready;
    logic [DATA_WIDTH-1:0]    pol_rsp_data, upd_rsp_data;
    logic [ACTIONS_WIDTH-1:0] pol_rsp_idx, upd_rsp_idx;
    logic                     mx_valid;
    logic [VW-1:0]            mx_data;
    logic                     mx_o_valid;
    logic [DATA_WIDTH-1:0]    mx_o_data;
    logic [ACTIONS_WIDTH-1:0] mx_o_at_max;
    logic                     err_sync;

    logic                     drop_en;
    logic                     m_v [3];
    logic [DATA_WIDTH+ACTIONS_WIDTH-1:0] m_r [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    max_share_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pol_req       (pol_req),
        .pol_data      (pol_data),
        .pol_ack       (pol_ack),
        .pol_rsp_valid (pol_rsp_valid),
        .pol_rsp_ready (pol_rsp_ready),
        .pol_rsp_data  (pol_rsp_data),
        .pol_rsp_idx   (pol_rsp_idx),
        .upd_req       (upd_req),
        .upd_data      (upd_data),
        .upd_ack       (upd_ack),
        .upd_rsp_valid (upd_rsp_valid),
        .upd_rsp_ready (upd_rsp_ready),
        .upd_rsp_data  (upd_rsp_data),
        .upd_rsp_idx   (upd_rsp_idx),
        .mx_valid      (mx_valid),
        .mx_data       (mx_data),
        .mx_o_valid    (mx_o_valid),
        .mx_o_data     (mx_o_data),
        .mx_o_at_max   (mx_o_at_max),
        .err_sync      (err_sync)
    );

    // Max-finder stand-in: three stages, lowest index wins ties.
    function automatic logic [DATA_WIDTH+ACTIONS_WIDTH-1:0] argmax(input logic [VW-1:0] v);
        logic [DATA_WIDTH-1:0]    best;
        logic [ACTIONS_WIDTH-1:0] bi;
        best = v[DATA_WIDTH-1:0];
        bi   = '0;
        for (int a = 1; a < ACTIONS; a++) begin
            if (v[a*DATA_WIDTH +: DATA_WIDTH] > best) begin
                best = v[a*DATA_WIDTH +: DATA_WIDTH];
                bi   = a[ACTIONS_WIDTH-1:0];
            end
        end
        return {best, bi};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin
                m_v[s] <= 1'b0;
                m_r[s] <= '0;
            end
        end else begin
            m_v[0] <= mx_valid && !drop_en;
            m_r[0] <= argmax(mx_data);
            for (int s = 1; s < 3; s++) begin
                m_v[s] <= m_v[s-1];
                m_r[s] <= m_r[s-1];
            end
        end
    end

    assign mx_o_valid  = m_v[2];
    assign mx_o_data   = m_r[2][DATA_WIDTH+ACTIONS_WIDTH-1:ACTIONS_WIDTH];
    assign mx_o_at_max = m_r[2][ACTIONS_WIDTH-1:0];

    function automatic logic [VW-1:0] qv(input int q0, input int q1, input int q2, input int q3);
        return {q3[DATA_WIDTH-1:0], q2[DATA_WIDTH-1:0], q1[DATA_WIDTH-1:0], q0[DATA_WIDTH-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        pol_req       = 1'b0;
        upd_req       = 1'b0;
        pol_data      = '0;
        upd_data      = '0;
        pol_rsp_ready = 1'b1;
        upd_rsp_ready = 1'b1;
        drop_en       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic outs_any;
    assign outs_any = pol_ack | upd_ack | pol_rsp_valid | upd_rsp_valid | mx_valid | (|mx_data)
                    | (|pol_rsp_data) | (|pol_rsp_idx) | (|upd_rsp_data) | (|upd_rsp_idx) | err_sync;

    initial begin
        int  pol_cnt;
        int  upd_cnt;
        bit  have_last;
        logic last_upd;

        // Reset state
        rst_n = 1'b0;
        #2;
        chk("reset_async_outputs", outs_any, 0);
        do_reset();
        chk("reset_outputs", outs_any, 0);

        // Single policy request: Q={5,9,2,7}
        pol_data = qv(5, 9, 2, 7);
        pol_req  = 1'b1;                 // cycle T
        step();                          // T+1
        chk("t1_pol_ack", pol_ack, 1);
        chk("t1_mx_valid", mx_valid, 1);
        chk("t1_mx_data", mx_data, qv(5, 9, 2, 7));
        chk("t1_upd_ack", upd_ack, 0);
        pol_req = 1'b0;
        step();                          // T+2
        chk("t1_ack_pulse", {pol_ack, mx_valid}, 0);
        step();
        step();                          // T+4
        chk("t1_rsp_not_early", pol_rsp_valid, 0);
        step();                          // T+5
        chk("t1_rsp_valid", pol_rsp_valid, 1);
        chk("t1_rsp_data", pol_rsp_data, 9);
        chk("t1_rsp_idx", pol_rsp_idx, 1);
        chk("t1_upd_quiet", {upd_ack, upd_rsp_valid}, 0);
        step();                          // T+6, consumed
        chk("t1_rsp_consumed", pol_rsp_valid, 0);

        // Simultaneous requests from reset
        do_reset();
        pol_data = qv(1, 2, 3, 4);
        upd_data = qv(8, 6, 8, 1);
        pol_req  = 1'b1;
        upd_req  = 1'b1;                 // T
        step();                          // T+1
        chk("t2_pol_first", {pol_ack, upd_ack}, 2'b10);
        chk("t2_mx_pol", mx_data, qv(1, 2, 3, 4));
        pol_req = 1'b0;
        step();                          // T+2
        chk("t2_upd_second", {pol_ack, upd_ack}, 2'b01);
        chk("t2_mx_b2b", {mx_valid, mx_data}, {1'b1, qv(8, 6, 8, 1)});
        upd_req = 1'b0;
        step();
        step();
        step();                          // T+5
        chk("t2_pol_rsp", {pol_rsp_valid, pol_rsp_data, pol_rsp_idx, upd_rsp_valid}, {1'b1, 16'd4, 2'd3, 1'b0});
        step();                          // T+6
        chk("t2_upd_rsp", {upd_rsp_valid, upd_rsp_data, upd_rsp_idx, pol_rsp_valid}, {1'b1, 16'd8, 2'd0, 1'b0});

        // Continuous requests from both ports: grants alternate, 6-cycle round trip per port
        do_reset();
        pol_data  = qv(3, 3, 7, 0);
        upd_data  = qv(0, 2, 1, 4);
        pol_req   = 1'b1;
        upd_req   = 1'b1;                // T
        pol_cnt   = 0;
        upd_cnt   = 0;
        have_last = 1'b0;
        last_upd  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (pol_ack || upd_ack) begin
                chk("t3_one_ack", pol_ack & upd_ack, 0);
                if (have_last) chk("t3_alternate", upd_ack, !last_upd);
                have_last = 1'b1;
                last_upd  = upd_ack;
                if (pol_ack) pol_cnt++;
                if (upd_ack) upd_cnt++;
            end
        end
        chk("t3_pol_count", pol_cnt, 5);
        chk("t3_upd_count", upd_cnt, 5);
        pol_req = 1'b0;
        upd_req = 1'b0;

        // upd response stalled for 10 cycles while pol is served
        do_reset();
        upd_data      = qv(3, 1, 4, 1);
        upd_rsp_ready = 1'b0;
        upd_req       = 1'b1;            // T
        step();                          // T+1
        chk("t4_upd_ack", upd_ack, 1);
        step();
        step();
        step();
        step();                          // T+5
        pol_data = qv(5, 9, 2, 7);
        pol_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_upd_hold", {upd_rsp_valid, upd_rsp_data, upd_rsp_idx, upd_ack}, {1'b1, 16'd4, 2'd2, 1'b0});
            chk("t4_pol_ack", pol_ack, (i == 1));
            if (i == 5) chk("t4_pol_rsp", {pol_rsp_valid, pol_rsp_data, pol_rsp_idx}, {1'b1, 16'd9, 2'd1});
            if (pol_ack) pol_req = 1'b0;
            step();
        end
        upd_req       = 1'b0;
        upd_rsp_ready = 1'b1;
        step();
        chk("t4_upd_consumed", {upd_rsp_valid, upd_ack}, 0);

        // Dropped result: err_sync sets and stays, port recovers
        do_reset();
        pol_data = qv(2, 11, 6, 11);
        pol_req  = 1'b1;
        drop_en  = 1'b1;                 // T
        step();                          // T+1
        chk("t5_pol_ack", pol_ack, 1);
        pol_req = 1'b0;
        step();                          // T+2
        drop_en = 1'b0;
        step();
        step();                          // T+4
        chk("t5_err_not_yet", err_sync, 0);
        step();                          // T+5
        chk("t5_err_set", {err_sync, pol_rsp_valid}, 2'b10);
        pol_req = 1'b1;
        step();                          // T+6
        chk("t5_reissue_ack", pol_ack, 1);
        pol_req = 1'b0;
        step();
        step();
        step();
        step();                          // T+10
        chk("t5_recovered", {pol_rsp_valid, pol_rsp_data, pol_rsp_idx}, {1'b1, 16'd11, 2'd1});
        chk("t5_err_sticky", err_sync, 1);

        // Reset with two requests in flight
        pol_data = qv(9, 1, 1, 1);
        upd_data = qv(1, 1, 1, 9);
        step();
        pol_req = 1'b1;
        upd_req = 1'b1;                  // T
        step();                          // T+1
        pol_req = 1'b0;
        step();                          // T+2
        upd_req = 1'b0;
        step();                          // T+3
        rst_n = 1'b0;
        #1;
        chk("t6_reset_clears", outs_any, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_quiet", {mx_o_valid, pol_rsp_valid, upd_rsp_valid, err_sync}, 0);
        end
        pol_data = qv(4, 0, 12, 3);
        pol_req  = 1'b1;                 // T
        step();                          // T+1
        chk("t6_ack", {pol_ack, mx_valid}, 2'b11);
        pol_req = 1'b0;
        step();
        step();
        step();                          // T+4
        chk("t6_rsp_not_early", pol_rsp_valid, 0);
        step();                          // T+5
        chk("t6_rsp", {pol_rsp_valid, pol_rsp_data, pol_rsp_idx}, {1'b1, 16'd12, 2'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
